// File: rtl/aes_ctr_pkg.sv
// Shared types and constants for the AES-192 CTR sequencer.
package aes_ctr_pkg;

  localparam int BLK_W = 128;
  localparam int KEY_W = 192;
  localparam logic [7:0] TIMEOUT_LIM = 8'd255;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    ARM   = 3'd2,
    WAIT  = 3'd3,
    HOLD  = 3'd4
  } state_t;

endpackage

// File: rtl/aes_ctr_inc32.sv
// Counter-block increment: the low CNT_W bits count modulo 2^CNT_W, upper bits pass through.
module aes_ctr_inc32
  import aes_ctr_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic [BLK_W-1:0] cnt,
  output logic [BLK_W-1:0] cnt_next,
  output logic             wrap
);

  logic [CNT_W-1:0] low_next;

  assign low_next = cnt[CNT_W-1:0] + {{(CNT_W-1){1'b0}}, 1'b1};
  assign wrap     = &cnt[CNT_W-1:0];
  assign cnt_next = {cnt[BLK_W-1:CNT_W], low_next};

endmodule

// File: rtl/aes_ctr_seq_192.sv
// AES-192 CTR-mode block sequencer driving an external aes_192 core.
// Optional WAIT watchdog enabled by defining AES_CTR_TIMEOUT_EN.
module aes_ctr_seq_192
  import aes_ctr_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             wb_clk_i,
  input  logic             wb_rst_i,
  input  logic [KEY_W-1:0] cfg_key_i,
  input  logic [BLK_W-1:0] cfg_iv_i,
  input  logic             load_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [BLK_W-1:0] in_data_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic [BLK_W-1:0] out_data_o,
  output logic             core_start_o,
  output logic [BLK_W-1:0] core_state_o,
  output logic [KEY_W-1:0] core_key_o,
  input  logic [BLK_W-1:0] core_out_i,
  input  logic             core_valid_i,
  output logic             busy_o,
  output logic             wrap_o,
  output logic             err_o,
  output logic [31:0]      blk_cnt_o
);

  state_t           state, state_nxt;
  logic [BLK_W-1:0] counter, counter_inc, data_lat, out_data;
  logic [31:0]      blk_cnt;
  logic             inc_wrap, out_valid, wrap;
  logic             do_load, accept, core_done, release_out, timeout;

  aes_ctr_inc32 #(.CNT_W(CNT_W)) u_inc (
    .cnt      (counter),
    .cnt_next (counter_inc),
    .wrap     (inc_wrap)
  );

  // load has priority over a simultaneous input offer
  assign do_load     = (state == IDLE) && load_i;
  assign in_ready_o  = (state == IDLE) && !load_i;
  assign accept      = in_ready_o && in_valid_i;
  assign core_done   = (state == WAIT) && core_valid_i;
  assign release_out = (state == HOLD) && out_ready_i;

  assign core_start_o = (state == START);
  assign core_state_o = counter;
  assign core_key_o   = cfg_key_i;
  assign busy_o       = (state != IDLE);
  assign out_valid_o  = out_valid;
  assign out_data_o   = out_data;
  assign wrap_o       = wrap;
  assign blk_cnt_o    = blk_cnt;

`ifdef AES_CTR_TIMEOUT_EN
  logic [7:0] wdog;
  logic       err;

  assign timeout = (state == WAIT) && !core_valid_i && (wdog == (TIMEOUT_LIM - 8'd1));
  assign err_o   = err;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wdog <= 8'd0;
      err  <= 1'b0;
    end else begin
      if ((state == WAIT) && !core_valid_i) wdog <= wdog + 8'd1;
      else                                  wdog <= 8'd0;
      if (do_load)      err <= 1'b0;
      else if (timeout) err <= 1'b1;
      else              err <= err;
    end
  end
`else
  assign timeout = 1'b0;
  assign err_o   = 1'b0;
`endif

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (accept) state_nxt = START; else state_nxt = IDLE;
      START: state_nxt = ARM;
      ARM:   state_nxt = WAIT;
      WAIT: begin
        if (core_valid_i) state_nxt = HOLD;
        else if (timeout) state_nxt = IDLE;
        else              state_nxt = WAIT;
      end
      HOLD:  if (out_ready_i) state_nxt = IDLE; else state_nxt = HOLD;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      counter   <= {BLK_W{1'b0}};
      data_lat  <= {BLK_W{1'b0}};
      out_data  <= {BLK_W{1'b0}};
      out_valid <= 1'b0;
      wrap      <= 1'b0;
      blk_cnt   <= 32'd0;
    end else begin
      if (do_load) begin
        counter <= cfg_iv_i;
        wrap    <= 1'b0;
        blk_cnt <= 32'd0;
      end else if (core_done) begin
        counter <= counter_inc;
        if (inc_wrap) wrap <= 1'b1;
      end else if (release_out) begin
        blk_cnt <= blk_cnt + 32'd1;
      end
      if (accept) data_lat <= in_data_i;
      if (core_done) begin
        out_data  <= data_lat ^ core_out_i;
        out_valid <= 1'b1;
      end else if (release_out) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: doc/aes_ctr_seq_192.md
AES_CTR_SEQ_192 -- requirements
Module: aes_ctr_seq_192

Interface
REQ-001 SHALL have parameter CNT_W, default 32, the width of the incrementing low counter field.
REQ-002 SHALL have port wb_clk_i, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port wb_rst_i, input, 1: reset, asynchronous, active-high.
REQ-004 SHALL have port cfg_key_i, input, 192: AES-192 key, passed through to core_key_o.
REQ-005 SHALL have port cfg_iv_i, input, 128: initial counter block.
REQ-006 SHALL have port load_i, input, 1: pulse; copies cfg_iv_i into the counter.
REQ-007 SHALL have ports in_valid_i (input, 1), in_ready_o (output, 1) and in_data_i (input, 128): plaintext block handshake.
REQ-008 SHALL have ports out_valid_o (output, 1), out_ready_i (input, 1) and out_data_o (output, 128): result block handshake.
REQ-009 SHALL have ports core_start_o (output, 1), core_state_o (output, 128) and core_key_o (output, 192): drive the downstream aes_192 core.
REQ-010 SHALL have ports core_out_i (input, 128) and core_valid_i (input, 1): the core's result and its valid flag.
REQ-011 SHALL have ports busy_o (output, 1), wrap_o (output, 1, sticky), err_o (output, 1, sticky) and blk_cnt_o (output, 32): status.

Function
REQ-012 SHALL implement the FSM states IDLE, START, ARM, WAIT and HOLD.
REQ-013 IDLE: in_ready_o=1 unless load_i=1; on in_valid_i&in_ready_o, latch in_data_i and go to START.
REQ-014 START: core_start_o=1 for exactly one cycle, core_state_o=counter; then go to ARM.
REQ-015 ARM: one cycle in which core_valid_i is ignored (stale valid from the previous block); then go to WAIT.
REQ-016 WAIT: when core_valid_i=1, register out_data_o = latched plaintext XOR core_out_i, set out_valid_o, increment the counter, and go to HOLD.
REQ-017 HOLD: out_valid_o and out_data_o stay stable until out_ready_i=1; on that cycle clear out_valid_o, increment blk_cnt_o, and go to IDLE.
REQ-018 Latency from input handshake (cycle N) to the core start pulse SHALL be 1 cycle (N+1); out_valid_o SHALL rise the cycle after core_valid_i is seen in WAIT.
REQ-019 Counter increment SHALL affect only bits [CNT_W-1:0] modulo 2^CNT_W; bits [127:CNT_W] SHALL be unchanged.
REQ-020 When the low field wraps from all-ones to 0, wrap_o SHALL set and stay set until load_i or reset.
REQ-021 load_i SHALL be honoured in IDLE only: it loads the counter and clears wrap_o, err_o and blk_cnt_o; outside IDLE it is ignored.
REQ-022 If load_i and in_valid_i arrive in the same IDLE cycle, load wins, in_ready_o=0, and the input is not consumed.
REQ-023 busy_o SHALL be 1 in every state except IDLE.
REQ-024 core_state_o SHALL be driven from the counter register; core_key_o SHALL equal cfg_key_i combinationally.
REQ-025 blk_cnt_o SHALL wrap modulo 2^32 without raising a flag.

Reset
REQ-026 Asserting wb_rst_i SHALL immediately force state IDLE; counter, latched data, out_data_o and blk_cnt_o to 0; out_valid_o, core_start_o, wrap_o and err_o to 0; in_ready_o to 1 after deassertion.
REQ-027 A reset during START, ARM, WAIT or HOLD SHALL abandon the block; no output SHALL be produced for it after deassertion.

Configuration
REQ-028 Macro AES_CTR_TIMEOUT_EN SHALL, when defined, add an 8-bit watchdog that counts cycles spent in WAIT.
REQ-029 If the watchdog reaches 255 without core_valid_i, the block SHALL set err_o, drop the block and return to IDLE; without the macro, err_o is tied to 0 and WAIT has no time limit.

Structure
REQ-030 Package aes_ctr_pkg SHALL hold the FSM state typedef, the 128/192-bit width constants and the timeout limit constant (255).
REQ-031 The counter increment SHALL be placed in sub-module aes_ctr_inc32, which outputs the next counter and a wrap flag.

Verification
REQ-032 Key 8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, IV f0f1...feff, load, input 6bc1bee22e409f96e93d7e117393172a -> out_data_o=1abc932417521ca24f2b0459fe7e6e0b; next counter low word = fcfdff00.
REQ-033 IV low word ffffffff, one block -> core_state_o low word ffffffff for that block; counter low word 00000000 afterwards; upper 96 bits unchanged; wrap_o=1.
REQ-034 out_ready_i held 0 for 10 cycles in HOLD -> out_data_o stable, in_ready_o=0, blk_cnt_o unchanged until the handshake.
REQ-035 load_i and in_valid_i asserted together in IDLE -> in_ready_o=0 that cycle, block not consumed; the block is accepted on the next cycle.
REQ-036 wb_rst_i pulsed in WAIT -> all outputs return to reset values; a later core_valid_i produces no out_valid_o.
REQ-037 With AES_CTR_TIMEOUT_EN and core_valid_i held at 0 -> err_o=1 exactly 255 cycles after entering WAIT; state returns to IDLE.
